ocx_tlx_rcv_vc_commit_fifo: RTL
===============================

// Module: ocx_tlx_rcv_vc_commit_fifo
// PURPOSE
//  Parametrised N-channel receive staging FIFO between the TLX flit parser and the AFU/CFG command/response
//  interfaces. Entries pushed by the parser stay tentative until the flit's CRC is confirmed good. They are
//  discarded on a CRC flush. Committed entries go to the AFU only against AFU-granted credits, and each
//  dispatch returns one TL credit per channel to the transmit side.
// PARAMETERS
//  NUM_VC   2    channel count (ch0 = cmd, ch1 = resp, ch2.. = cfg/extra)
//  INFO_W   168  info bits per entry
//  DEPTH    16   entries per channel, power of 2, >=2
//  CRD_W    7    AFU credit counter width (matches afu_tlx_*_initial_credit)
// PORTS
//  tlx_clk                 in   1              clock
//  reset                   in   1              synchronous, active-high
//  fp_push_valid           in   NUM_VC         parser push strobe per channel
//  fp_push_info            in   NUM_VC*INFO_W  entry payload, ch i at [i*INFO_W +: INFO_W]
//  good_crc                in   1              commit all tentative entries, all channels
//  crc_flush               in   1              discard all tentative entries, all channels
//  afu_init_credit_v       in   NUM_VC         load initial credit for the channel
//  afu_init_credit         in   NUM_VC*CRD_W   initial credit value
//  afu_credit              in   NUM_VC         +1 credit return from AFU
//  tlx_afu_valid           out  NUM_VC         dispatch strobe
//  tlx_afu_info            out  NUM_VC*INFO_W  dispatched payload
//  rcv_xmt_credit_v        out  NUM_VC         one-cycle TL credit return to xmt
//  rcv_err_overflow        out  NUM_VC         sticky: push while full
//  rcv_err_credit          out  NUM_VC         sticky: AFU credit counter overflow
//  rcv_err_crc_collide     out  1              sticky: good_crc and crc_flush in the same cycle
// BEHAVIOUR
//  - Reset: all outputs 0; pointers, counters and sticky errors 0; AFU credit 0 (no dispatch until loaded).
//  - Per-channel state: wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits with a wrap bit.
//    occupancy = wr_ptr - rd_ptr; committed = commit_ptr - rd_ptr.
//  - Push: if occupancy < DEPTH, write at wr_ptr and wr_ptr++. If full, drop the entry and set rcv_err_overflow[i].
//  - good_crc (alone): commit_ptr <= wr_ptr, including a push in the same cycle.
//  - crc_flush (alone): wr_ptr <= commit_ptr. A push in the same cycle is discarded and causes no overflow error.
//  - good_crc and crc_flush together: flush wins, commit_ptr is unchanged, rcv_err_crc_collide is set.
//  - Dispatch condition per cycle: committed > 0 and credit > 0. When it holds: rd_ptr++ and credit--.
//    Next cycle: tlx_afu_valid[i]=1, tlx_afu_info = entry, rcv_xmt_credit_v[i]=1. Latency is 1 clock.
//    Back-to-back dispatch is allowed, one per clock per channel.
//  - A push that is committed in cycle t is dispatchable in cycle t+1 and appears at the output in cycle t+2.
//  - Credit update, in priority order: init load sets credit = value (same-cycle dispatch/return ignored).
//    Otherwise credit += afu_credit - dispatch. A simultaneous return and dispatch nets 0.
//    Increment at max: saturate at 2^CRD_W-1 and set rcv_err_credit[i].
//  - Flush never touches committed or dispatched entries. rd_ptr never passes commit_ptr.
//  - Reset mid-operation drops all entries. In-flight outputs clear the next cycle. No credit is returned.
//  - Channels are fully independent; there is no cross-channel arbitration.
// STRUCTURE
//  - Shared include ocx_tlx_rcv_defs.vh: channel index constants (RCV_VC_CMD=0, RCV_VC_RESP=1, RCV_VC_CFG=2),
//    default INFO_W/DEPTH/CRD_W.
//  - Sub-module ocx_tlx_rcv_commit_fifo: one channel (storage, three pointers, credit counter, error bits).
//    The top generates NUM_VC instances and shares good_crc/crc_flush; the collide flag is computed in the top.
//  - Storage is a register array, DEPTH x INFO_W, with no output register beyond the dispatch flop.
// TESTING
//  1. Load credit 2 on ch0. Push A, B, C, then good_crc -> A and B dispatched on consecutive cycles.
//     Two rcv_xmt_credit_v pulses. C held. afu_credit=1 -> C dispatched 1 clock later.
//  2. Push 3 on ch1, good_crc, push 2 more, crc_flush -> only the first 3 dispatch. occupancy=0 after.
//     A later push lands at the old wr position.
//  3. DEPTH=4, credit 0: push 5 uncommitted -> 5th dropped, rcv_err_overflow[0]=1. Flush -> empty, error stays.
//  4. Push in the same cycle as good_crc+crc_flush -> push discarded, nothing committed, rcv_err_crc_collide=1.
//  5. Credit at 127, afu_credit -> stays 127, rcv_err_credit=1.
//     Credit 1 with simultaneous dispatch and afu_credit -> credit stays 1.
//  6. NUM_VC=3: traffic on all channels at once, reset asserted mid-burst -> all outputs 0 the next cycle.
//     After reset, no dispatch until afu_init_credit_v.

Source files
------------

// File: rtl/ocx_tlx_rcv_vc_commit_fifo_pkg.sv
// Shared constants and helpers for the TLX receive commit FIFO.
// Channel indices, default geometry and the credit-update selector.
package ocx_tlx_rcv_vc_commit_fifo_pkg;

  localparam int RCV_VC_CMD  = 0;
  localparam int RCV_VC_RESP = 1;
  localparam int RCV_VC_CFG  = 2;

  localparam int RCV_NUM_VC  = 2;
  localparam int RCV_INFO_W  = 168;
  localparam int RCV_DEPTH   = 16;
  localparam int RCV_CRD_W   = 7;

  typedef enum logic [1:0] {
    CRD_HOLD,
    CRD_LOAD,
    CRD_INC,
    CRD_DEC
  } crd_op_e;

  // Init load overrides everything; a return and a
  // dispatch in the same cycle cancel out.
  function automatic crd_op_e crd_op(
    input logic load,
    input logic inc,
    input logic dec
  );
    crd_op_e op;
    op = CRD_HOLD;
    if (load)            op = CRD_LOAD;
    else if (inc && !dec) op = CRD_INC;
    else if (dec && !inc) op = CRD_DEC;
    return op;
  endfunction

endpackage

// File: rtl/ocx_tlx_rcv_commit_fifo.sv
// One receive channel: tentative/committed storage, three
// pointers, AFU credit counter, sticky error bits.
//
// Ports:
//  clk_i, reset_i          clock, sync active-high reset
//  push_valid_i/info_i     parser push
//  commit_i / flush_i      good_crc / crc_flush (flush wins)
//  init_credit_v_i/_i      AFU initial credit load
//  afu_credit_i            +1 AFU credit return
//  valid_o / info_o        dispatch (1 clock after decision)
//  xmt_credit_v_o          TL credit return pulse
//  err_overflow_o          sticky push-while-full
//  err_credit_o            sticky credit overflow
module ocx_tlx_rcv_commit_fifo
  import ocx_tlx_rcv_vc_commit_fifo_pkg::*;
#(
  parameter int INFO_W = RCV_INFO_W,
  parameter int DEPTH  = RCV_DEPTH,
  parameter int CRD_W  = RCV_CRD_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_valid_i,
  input  logic [INFO_W-1:0] push_info_i,
  input  logic              commit_i,
  input  logic              flush_i,
  input  logic              init_credit_v_i,
  input  logic [CRD_W-1:0]  init_credit_i,
  input  logic              afu_credit_i,
  output logic              valid_o,
  output logic [INFO_W-1:0] info_o,
  output logic              xmt_credit_v_o,
  output logic              err_overflow_o,
  output logic              err_credit_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  localparam ptr_t             FULL_OCC = ptr_t'(DEPTH);
  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
  localparam logic [CRD_W-1:0] CRD_MAX  = '1;

  logic [INFO_W-1:0] mem_q [DEPTH];

  ptr_t wr_q, wr_d;
  ptr_t cm_q, cm_d;
  ptr_t rd_q, rd_d;
  ptr_t occ, cmt;

  logic [CRD_W-1:0]  crd_q, crd_d;
  logic              ovf_q, ovf_d;
  logic              cerr_q, cerr_d;
  logic              vld_q, vld_d;
  logic [INFO_W-1:0] info_q, info_d;

  logic full;
  logic push_ok;
  logic disp;
  logic do_commit;

  always_comb begin
    occ       = wr_q - rd_q;
    cmt       = cm_q - rd_q;
    full      = (occ == FULL_OCC);
    do_commit = commit_i && !flush_i;
    // A flushed cycle discards its own push silently.
    push_ok   = push_valid_i && !flush_i && !full;
    disp      = (cmt != '0) && (crd_q != '0);

    wr_d = flush_i ? cm_q : wr_q + ptr_t'(push_ok);
    // Commit covers a push landing in the same cycle.
    cm_d = do_commit ? wr_q + ptr_t'(push_ok) : cm_q;
    rd_d = rd_q + ptr_t'(disp);

    ovf_d  = ovf_q | (push_valid_i & ~flush_i & full);
    vld_d  = disp;
    info_d = disp ? mem_q[rd_q[AW-1:0]] : '0;

    crd_d  = crd_q;
    cerr_d = cerr_q;
    unique case (crd_op(init_credit_v_i, afu_credit_i, disp))
      CRD_LOAD: crd_d = init_credit_i;
      CRD_INC: begin
        if (crd_q == CRD_MAX) cerr_d = 1'b1;
        else                  crd_d  = crd_q + CRD_ONE;
      end
      CRD_DEC:  crd_d = crd_q - CRD_ONE;
      CRD_HOLD: crd_d = crd_q;
    endcase
  end

  // Storage carries no reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_info_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      crd_q  <= '0;
      ovf_q  <= 1'b0;
      cerr_q <= 1'b0;
      vld_q  <= 1'b0;
      info_q <= '0;
    end else begin
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      crd_q  <= crd_d;
      ovf_q  <= ovf_d;
      cerr_q <= cerr_d;
      vld_q  <= vld_d;
      info_q <= info_d;
    end
  end

  assign valid_o        = vld_q;
  assign info_o         = info_q;
  assign xmt_credit_v_o = vld_q;
  assign err_overflow_o = ovf_q;
  assign err_credit_o   = cerr_q;

endmodule

// File: rtl/ocx_tlx_rcv_vc_commit_fifo.sv
// N-channel TLX receive staging FIFO with CRC commit/flush
// and AFU credit gating; one independent FIFO per channel.
//
// Ports:
//  tlx_clk, reset              clock, sync active-high reset
//  fp_push_valid/_info         parser pushes, ch i at slice i
//  good_crc, crc_flush         commit / discard tentative
//  afu_init_credit_v/_credit   per-channel credit load
//  afu_credit                  per-channel +1 return
//  tlx_afu_valid/_info         dispatch to AFU
//  rcv_xmt_credit_v            TL credit return to xmt
//  rcv_err_*                   sticky error flags
module ocx_tlx_rcv_vc_commit_fifo
  import ocx_tlx_rcv_vc_commit_fifo_pkg::*;
#(
  parameter int NUM_VC = RCV_NUM_VC,
  parameter int INFO_W = RCV_INFO_W,
  parameter int DEPTH  = RCV_DEPTH,
  parameter int CRD_W  = RCV_CRD_W
) (
  input  logic                     tlx_clk,
  input  logic                     reset,
  input  logic [NUM_VC-1:0]        fp_push_valid,
  input  logic [NUM_VC*INFO_W-1:0] fp_push_info,
  input  logic                     good_crc,
  input  logic                     crc_flush,
  input  logic [NUM_VC-1:0]        afu_init_credit_v,
  input  logic [NUM_VC*CRD_W-1:0]  afu_init_credit,
  input  logic [NUM_VC-1:0]        afu_credit,
  output logic [NUM_VC-1:0]        tlx_afu_valid,
  output logic [NUM_VC*INFO_W-1:0] tlx_afu_info,
  output logic [NUM_VC-1:0]        rcv_xmt_credit_v,
  output logic [NUM_VC-1:0]        rcv_err_overflow,
  output logic [NUM_VC-1:0]        rcv_err_credit,
  output logic                     rcv_err_crc_collide
);

  logic collide_q, collide_d;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    ocx_tlx_rcv_commit_fifo #(
      .INFO_W (INFO_W),
      .DEPTH  (DEPTH),
      .CRD_W  (CRD_W)
    ) u_fifo (
      .clk_i           (tlx_clk),
      .reset_i         (reset),
      .push_valid_i    (fp_push_valid[g]),
      .push_info_i     (fp_push_info[g*INFO_W +: INFO_W]),
      .commit_i        (good_crc),
      .flush_i         (crc_flush),
      .init_credit_v_i (afu_init_credit_v[g]),
      .init_credit_i   (afu_init_credit[g*CRD_W +: CRD_W]),
      .afu_credit_i    (afu_credit[g]),
      .valid_o         (tlx_afu_valid[g]),
      .info_o          (tlx_afu_info[g*INFO_W +: INFO_W]),
      .xmt_credit_v_o  (rcv_xmt_credit_v[g]),
      .err_overflow_o  (rcv_err_overflow[g]),
      .err_credit_o    (rcv_err_credit[g])
    );
  end

  always_comb begin
    collide_d = collide_q | (good_crc & crc_flush);
  end

  always_ff @(posedge tlx_clk) begin
    if (reset) collide_q <= 1'b0;
    else       collide_q <= collide_d;
  end

  assign rcv_err_crc_collide = collide_q;

endmodule
